// File: rtl/store_align_buffer.sv
// Store alignment and in-order store buffer: lane-replicates SB/SH/SW data, builds
// active-low byte enables, and drains entries to data memory over a req/ack handshake.
module store_align_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_err,
    input  logic [31:0] ld_check_addr,
    output logic        ld_hazard,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_web,
    input  logic        dm_ack,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [29:0]   ent_addr_q  [DEPTH];
    logic [31:0]   ent_wdata_q [DEPTH];
    logic [3:0]    ent_web_q   [DEPTH];

    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [0:0]    state_q, state_d;
    logic          dm_req_q, dm_req_d;
    logic [31:0]   dm_addr_q, dm_addr_d;
    logic [31:0]   dm_wdata_q, dm_wdata_d;
    logic [3:0]    dm_web_q, dm_web_d;
    logic          st_err_q, st_err_d;

    logic          al_err;
    logic [31:0]   al_wdata;
    logic [3:0]    al_web;
    logic          accept, enq, pop;
    logic          unused_ld_bits;

    assign unused_ld_bits = ^ld_check_addr[1:0];

    always_comb begin
        al_err   = 1'b0;
        al_wdata = st_data;
        al_web   = 4'b1111;
        case (st_funct3)
            3'b000: begin
                al_wdata = {4{st_data[7:0]}};
                al_web   = ~(4'b0001 << st_addr[1:0]);
            end
            3'b001: begin
                al_wdata = {2{st_data[15:0]}};
                al_web   = st_addr[1] ? 4'b0011 : 4'b1100;
                al_err   = st_addr[0];
            end
            3'b010: begin
                al_web   = 4'b0000;
                al_err   = |st_addr[1:0];
            end
            default: al_err = 1'b1;
        endcase
    end

    assign st_ready = (count_q < FULL_CNT);
    assign accept   = st_valid && st_ready;
    assign enq      = accept && !al_err;
    assign pop      = (state_q == S_BUSY) && dm_ack;
    assign head_nxt = head_q + PW'(1);

    // Entry payload is data only; validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[tail_q]  <= st_addr[31:2];
            ent_wdata_q[tail_q] <= al_wdata;
            ent_web_q[tail_q]   <= al_web;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        dm_req_d   = dm_req_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_web_d   = dm_web_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    dm_req_d   = 1'b1;
                    dm_addr_d  = {ent_addr_q[head_q], 2'b00};
                    dm_wdata_d = ent_wdata_q[head_q];
                    dm_web_d   = ent_web_q[head_q];
                    state_d    = S_BUSY;
                end
            end
            default: begin
                if (dm_ack) begin
                    head_d = head_nxt;
                    // Only entries already counted qualify; a same-cycle enqueue waits for IDLE.
                    if (count_q > (PW+1)'(1)) begin
                        dm_addr_d  = {ent_addr_q[head_nxt], 2'b00};
                        dm_wdata_d = ent_wdata_q[head_nxt];
                        dm_web_d   = ent_web_q[head_nxt];
                    end else begin
                        dm_req_d = 1'b0;
                        dm_web_d = 4'b1111;
                        state_d  = S_IDLE;
                    end
                end
            end
        endcase
        tail_d   = enq ? tail_q + PW'(1) : tail_q;
        st_err_d = accept && al_err;
        case ({enq, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            state_q    <= S_IDLE;
            dm_req_q   <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_web_q   <= 4'b1111;
            st_err_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_web_q   <= dm_web_d;
            st_err_q   <= st_err_d;
        end
    end

    // The in-flight entry is still counted, so it participates in the hazard match.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(PW'(i) - head_q)} < count_q) &&
                (ent_addr_q[i] == ld_check_addr[31:2]))
                ld_hazard = 1'b1;
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign dm_web   = dm_web_q;
    assign st_err   = st_err_q;
    assign empty    = (count_q == '0);

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: alignment vector table, directed multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_store_align_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_err;
    logic [31:0] ld_check_addr;
    logic        ld_hazard;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_web;
    logic        dm_ack;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_align_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
        .st_addr(st_addr), .st_data(st_data), .st_err(st_err),
        .ld_check_addr(ld_check_addr), .ld_hazard(ld_hazard),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_web(dm_web),
        .dm_ack(dm_ack), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_web;
    } vec_t;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] wd;
        logic [3:0]  wb;
    } ent_t;

    vec_t vecs[14];
    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!dm_req && n < 10) begin
            tick();
            n++;
        end
        chk(name, {31'd0, dm_req}, 32'd1);
    endtask

    task automatic put(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        put(v.f3, v.addr, v.data);
        tick();
        st_valid = 1'b0;
        chk($sformatf("vec%0d_err", idx), {31'd0, st_err}, {31'd0, v.err});
        if (!v.err) begin
            wait_req($sformatf("vec%0d_req", idx));
            chk($sformatf("vec%0d_addr", idx), dm_addr, v.exp_addr);
            chk($sformatf("vec%0d_wdata", idx), dm_wdata, v.exp_wdata);
            chk($sformatf("vec%0d_web", idx), {28'd0, dm_web}, {28'd0, v.exp_web});
            dm_ack = 1'b1;
            tick();
            dm_ack = 1'b0;
            chk($sformatf("vec%0d_req_drop", idx), {31'd0, dm_req}, 32'd0);
            chk($sformatf("vec%0d_web_idle", idx), {28'd0, dm_web}, 32'hF);
        end else begin
            tick();
            chk($sformatf("vec%0d_err_pulse", idx), {31'd0, st_err}, 32'd0);
            chk($sformatf("vec%0d_noreq", idx), {31'd0, dm_req}, 32'd0);
        end
        chk($sformatf("vec%0d_empty", idx), {31'd0, empty}, 32'd1);
    endtask

    // Reference alignment computed arithmetically from the access size.
    function automatic ent_t model_align(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
        ent_t e;
        int   sz;
        logic [3:0] mask;
        sz   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        mask = (sz == 1) ? 4'h1 : (sz == 2) ? 4'h3 : 4'hF;
        e.wa = a[31:2];
        e.wd = (sz == 1) ? d[7:0] * 32'h01010101 :
               (sz == 2) ? d[15:0] * 32'h00010001 : d;
        e.wb = ~(mask << (a % 4));
        return e;
    endfunction

    function automatic bit model_err(input logic [2:0] f3, input logic [31:0] a);
        if (f3 > 3'd2) return 1'b1;
        return (a % (32'd1 << f3)) != 0;
    endfunction

    initial begin
        vecs[0]  = '{3'b000, 32'h103, 32'h000000AB, 1'b0, 32'h100, 32'hABABABAB, 4'b0111};
        vecs[1]  = '{3'b000, 32'h100, 32'h1234565A, 1'b0, 32'h100, 32'h5A5A5A5A, 4'b1110};
        vecs[2]  = '{3'b000, 32'h105, 32'hFFFFFF01, 1'b0, 32'h104, 32'h01010101, 4'b1101};
        vecs[3]  = '{3'b000, 32'h10A, 32'h00000077, 1'b0, 32'h108, 32'h77777777, 4'b1011};
        vecs[4]  = '{3'b001, 32'h202, 32'h1234ABCD, 1'b0, 32'h200, 32'hABCDABCD, 4'b0011};
        vecs[5]  = '{3'b001, 32'h200, 32'hFFFF5678, 1'b0, 32'h200, 32'h56785678, 4'b1100};
        vecs[6]  = '{3'b001, 32'h201, 32'h11112222, 1'b1, 32'h0,   32'h0,        4'b1111};
        vecs[7]  = '{3'b010, 32'h300, 32'hDEADBEEF, 1'b0, 32'h300, 32'hDEADBEEF, 4'b0000};
        vecs[8]  = '{3'b010, 32'h301, 32'hDEADBEEF, 1'b1, 32'h0,   32'h0,        4'b1111};
        vecs[9]  = '{3'b010, 32'h302, 32'h01234567, 1'b1, 32'h0,   32'h0,        4'b1111};
        vecs[10] = '{3'b011, 32'h400, 32'h01234567, 1'b1, 32'h0,   32'h0,        4'b1111};
        vecs[11] = '{3'b100, 32'h400, 32'h01234567, 1'b1, 32'h0,   32'h0,        4'b1111};
        vecs[12] = '{3'b111, 32'h404, 32'h01234567, 1'b1, 32'h0,   32'h0,        4'b1111};
        vecs[13] = '{3'b010, 32'hFFFFFFFC, 32'hCAFEF00D, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D, 4'b0000};

        rst = 1'b1;
        st_valid = 1'b0;
        st_funct3 = 3'd0;
        st_addr = '0;
        st_data = '0;
        ld_check_addr = '0;
        dm_ack = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_web", {28'd0, dm_web}, 32'hF);
        chk("rst_err", {31'd0, st_err}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, st_ready}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Back-to-back drain with ack held high.
        dm_ack = 1'b1;
        put(3'b001, 32'h202, 32'h1234ABCD);
        tick();
        put(3'b010, 32'h300, 32'hDEADBEEF);
        tick();
        st_valid = 1'b0;
        wait_req("b2b_req");
        chk("b2b_addr0", dm_addr, 32'h200);
        chk("b2b_wdata0", dm_wdata, 32'hABCDABCD);
        chk("b2b_web0", {28'd0, dm_web}, 32'h3);
        tick();
        chk("b2b_req1", {31'd0, dm_req}, 32'd1);
        chk("b2b_addr1", dm_addr, 32'h300);
        chk("b2b_wdata1", dm_wdata, 32'hDEADBEEF);
        chk("b2b_web1", {28'd0, dm_web}, 32'h0);
        tick();
        chk("b2b_drop", {31'd0, dm_req}, 32'd0);
        chk("b2b_empty", {31'd0, empty}, 32'd1);
        dm_ack = 1'b0;

        // Fill to DEPTH, hold, then release.
        for (int i = 0; i < 4; i++) begin
            put(3'b010, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        put(3'b010, 32'h20, 32'hBAD0BAD0);
        #1;
        chk("full_ready", {31'd0, st_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_req", {31'd0, dm_req}, 32'd1);
            chk("full_addr_hold", dm_addr, 32'h10);
            chk("full_wdata_hold", dm_wdata, 32'hA0);
            chk("full_ready_hold", {31'd0, st_ready}, 32'd0);
        end
        st_valid = 1'b0;
        dm_ack = 1'b1;
        #1;
        chk("full_pop_ready", {31'd0, st_ready}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            if (i == 1) chk("full_ready_after", {31'd0, st_ready}, 32'd1);
            chk("drain_req", {31'd0, dm_req}, 32'd1);
            chk("drain_addr", dm_addr, 32'h10 + 32'(4 * i));
            chk("drain_wdata", dm_wdata, 32'hA0 + 32'(i));
        end
        tick();
        dm_ack = 1'b0;
        chk("drain_done", {31'd0, dm_req}, 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Load hazard against a pending store.
        put(3'b010, 32'h400, 32'h55AA55AA);
        tick();
        st_valid = 1'b0;
        ld_check_addr = 32'h402;
        #1;
        chk("hz_queued", {31'd0, ld_hazard}, 32'd1);
        wait_req("hz_req");
        chk("hz_inflight", {31'd0, ld_hazard}, 32'd1);
        ld_check_addr = 32'h404;
        #1;
        chk("hz_other", {31'd0, ld_hazard}, 32'd0);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        ld_check_addr = 32'h402;
        #1;
        chk("hz_cleared", {31'd0, ld_hazard}, 32'd0);

        // Asynchronous reset while busy.
        for (int i = 0; i < 3; i++) begin
            put(3'b010, 32'h500 + 32'(4 * i), 32'h1000 + 32'(i));
            tick();
        end
        st_valid = 1'b0;
        wait_req("rstb_req");
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rstb_req_low", {31'd0, dm_req}, 32'd0);
        chk("rstb_web", {28'd0, dm_web}, 32'hF);
        chk("rstb_empty", {31'd0, empty}, 32'd1);
        tick();
        rst = 1'b0;
        dm_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rstb_no_write", {31'd0, dm_req}, 32'd0);
        end
        dm_ack = 1'b0;
        tick();

        // Randomized traffic against the queue model.
        begin
            bit exp_err = 1'b0;
            int starve = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit acc, pop, e_err, hz;
                int r;
                chk("rnd_st_err", {31'd0, st_err}, {31'd0, exp_err});
                if (dm_req) begin
                    starve = 0;
                    if (mq.size() == 0) begin
                        chk("rnd_req_when_empty", {31'd0, dm_req}, 32'd0);
                    end else begin
                        chk("rnd_dm_addr", dm_addr, {mq[0].wa, 2'b00});
                        chk("rnd_dm_wdata", dm_wdata, mq[0].wd);
                        chk("rnd_dm_web", {28'd0, dm_web}, {28'd0, mq[0].wb});
                    end
                end else begin
                    chk("rnd_idle_web", {28'd0, dm_web}, 32'hF);
                    if (mq.size() > 0) starve++;
                    if (starve > 2) begin
                        chk("rnd_drain_stall", {31'd0, dm_req}, 32'd1);
                        starve = 0;
                    end
                end

                r = $urandom_range(0, 9);
                st_valid  = ($urandom_range(0, 2) != 0);
                st_funct3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
                st_addr   = 32'h1000 | 32'($urandom_range(0, 63));
                st_data   = $urandom;
                ld_check_addr = 32'h1000 | 32'($urandom_range(0, 63));
                dm_ack    = ($urandom_range(0, 2) == 0);
                #1;

                hz = 1'b0;
                foreach (mq[k]) if (mq[k].wa == ld_check_addr[31:2]) hz = 1'b1;
                chk("rnd_ready", {31'd0, st_ready}, {31'd0, mq.size() < DEPTH});
                chk("rnd_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
                chk("rnd_hazard", {31'd0, ld_hazard}, {31'd0, hz});

                acc   = st_valid && (mq.size() < DEPTH);
                pop   = dm_req && dm_ack;
                e_err = model_err(st_funct3, st_addr);
                exp_err = acc && e_err;
                if (pop && mq.size() > 0) void'(mq.pop_front());
                if (acc && !e_err) mq.push_back(model_align(st_funct3, st_addr, st_data));
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Write-direction counterpart of the load extraction path.
- Accepts SB/SH/SW requests from the MEM stage and replicates store data into byte lanes.
- Generates active-low per-byte write enables and queues requests in a small in-order store buffer.
- Drains the buffer to data memory over a req/ack handshake; flags load addresses that hit a pending store so the pipeline can stall.

Parameters:
DEPTH, 4, number of store buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept a request this cycle
st_funct3  in  3  000=SB, 001=SH, 010=SW; other values unsupported
st_addr  in  32  byte address (ALU result)
st_data  in  32  rs2 value
st_err  out  1  registered; one-cycle pulse after accepting a misaligned/unsupported request
ld_check_addr  in  32  byte address of the load currently in MEM
ld_hazard  out  1  combinational; a pending store matches ld_check_addr[31:2]
dm_req  out  1  registered; write request to data memory
dm_addr  out  32  registered; word-aligned address, bits [1:0] = 00
dm_wdata  out  32  registered; lane-replicated write data
dm_web  out  4  registered; active-low byte write enable, bit i = byte lane i
dm_ack  in  1  memory accepted the current write (sampled while dm_req=1)
empty  out  1  no entries pending, including the one in flight

Behaviour:
- Reset (async, immediate): count=0, FSM=IDLE, dm_req=0, dm_addr=0, dm_wdata=0, dm_web=4'b1111, st_err=0. Buffered and in-flight stores are discarded.
- st_ready = (count < DEPTH). A request is accepted when st_valid && st_ready.
- Full-with-pop: a pop in the same cycle does not raise st_ready; st_ready rises the cycle after.
- Alignment is computed at accept and stored per entry as {word addr, wdata, web}:
  - SB: wdata = {4{data[7:0]}}; web = all 1 except bit addr[1:0] = 0.
  - SH: wdata = {2{data[15:0]}}; web = 1100 if addr[1]=0, else 0011. addr[0]=1 is an error.
  - SW: wdata = data; web = 0000. addr[1:0] != 00 is an error.
- Error requests (misaligned, or funct3 not in {000,001,010}) are consumed, never enqueued, and raise st_err for exactly one cycle after acceptance.
- Drain FSM:
  - IDLE: if count>0, register the head entry onto dm_* and set dm_req=1 -> BUSY. Earliest dm_req is the cycle after acceptance.
  - BUSY: dm_addr, dm_wdata and dm_web are held stable until dm_ack.
  - On dm_ack: pop head, decrement count. If entries remain (excluding any enqueued the same cycle), load the next head and stay BUSY (back-to-back). Otherwise dm_req=0, dm_web=1111 -> IDLE.
- Simultaneous enqueue and pop: count unchanged; a new entry never bypasses older ones.
- dm_ack while IDLE is ignored.
- The in-flight entry stays counted and stays visible to ld_hazard until its dm_ack.
- ld_hazard = OR over all valid entries of (entry word addr == ld_check_addr[31:2]). Combinational, no byte-mask refinement.
- empty = (count == 0).
- Pointers wrap modulo DEPTH.

Test Plan:
- SB addr 0x103, data 0x000000AB, dm_ack one cycle after dm_req -> dm_addr 0x100, dm_wdata 0xABABABAB, dm_web 0111; dm_req drops after ack; empty=1.
- SH 0x202 data 0x1234ABCD, then SW 0x300 data 0xDEADBEEF, dm_ack held 1 -> back-to-back: 0x200/0xABCDABCD/0011, then 0x300/0xDEADBEEF/0000 on consecutive cycles.
- SW 0x301, then funct3=011 at 0x400 -> st_err pulses once after each accept; no dm_req; empty stays 1.
- Four SW (0x10, 0x14, 0x18, 0x1C), dm_ack=0 -> st_ready=0 after the fourth; dm_* stays stable on 0x10; release ack -> drains in order; st_ready=1 the cycle after the first ack.
- Pending SW 0x400, dm_ack=0 -> ld_check_addr 0x402 gives ld_hazard=1, 0x404 gives 0; after ack, 0x402 gives 0.
- rst asserted while BUSY with 3 entries -> dm_req=0 and dm_web=1111 immediately; empty=1; no write issued after rst is released.
